// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and float/fixed conversion helpers for the
// parametrised CORDIC sine/cosine unit.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CONV,
        ST_DONE
    } state_t;

    // CORDIC gain compensation 0.6072529350 in Q1.31
    localparam logic [31:0] K_Q31    = 32'd1304065748;
    localparam logic [31:0] NAN_BITS = 32'h7FC0_0000;

    // atan(2^-i) in Q1.27
    function automatic logic [31:0] atan_q27(input int i);
        case (i)
            0:       return 32'd105414357;
            1:       return 32'd62229729;
            2:       return 32'd32880480;
            3:       return 32'd16690645;
            4:       return 32'd8377711;
            5:       return 32'd4192939;
            6:       return 32'd2096981;
            7:       return 32'd1048555;
            8:       return 32'd524285;
            9:       return 32'd262144;
            10:      return 32'd131072;
            11:      return 32'd65536;
            12:      return 32'd32768;
            13:      return 32'd16384;
            14:      return 32'd8192;
            15:      return 32'd4096;
            16:      return 32'd2048;
            17:      return 32'd1024;
            18:      return 32'd512;
            19:      return 32'd256;
            20:      return 32'd128;
            21:      return 32'd64;
            22:      return 32'd32;
            23:      return 32'd16;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] atan_fixed(input int i, input int width);
        int sh;
        logic [31:0] v;
        sh = 28 - width;
        v  = atan_q27(i);
        if (sh == 0) return v;
        return (v + (32'd1 << (sh - 1))) >> sh;
    endfunction

    // Truncated so that WIDTH=21 lands on 0x09B74E
    function automatic logic [31:0] k_fixed(input int width);
        return K_Q31 >> (32 - width);
    endfunction

    function automatic logic float_is_bad(input logic [31:0] f);
        return f[30:23] >= 8'd127;
    endfunction

    // |f| as Q1.(width-1); out-of-range inputs return 0 and are flagged separately
    function automatic logic [31:0] float_to_fixed(input logic [31:0] f, input int width);
        logic [31:0] mag;
        mag = {1'b1, f[22:0], 8'd0} >> (32 - width);
        if (f[30:23] == 8'd0 || f[30:23] >= 8'd127) return 32'd0;
        return mag >> (8'd127 - f[30:23]);
    endfunction

    // v is the sign-extended Q1.(width-1) magnitude; negative values clamp to +0
    function automatic logic [31:0] fixed_to_float(input logic [31:0] v, input int width,
                                                   input logic neg);
        int p;
        logic [31:0] norm;
        logic [7:0] e;
        p = 0;
        if (v[31] || v == 32'd0) return 32'd0;
        for (int b = 0; b < 32; b++) begin
            if (v[b]) p = b;
        end
        norm = v << (31 - p);
        e    = 8'(127 + p - (width - 1));
        return {neg, e, norm[30:8]};
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode.
module cordic_stage #(
    parameter int WIDTH = 21
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] z_i,
    input  logic        [4:0]       shift_i,
    input  logic signed [WIDTH-1:0] angle_i,
    output logic signed [WIDTH-1:0] x_o,
    output logic signed [WIDTH-1:0] y_o,
    output logic signed [WIDTH-1:0] z_o
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;

    assign x_sh = x_i >>> shift_i;
    assign y_sh = y_i >>> shift_i;

    always_comb begin
        if (z_i[WIDTH-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + angle_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - angle_i;
        end
    end

endmodule

// File: rtl/cordic_param_sincos.sv
// Multi-cycle custom instruction computing cos/sin of a float angle |a| < 1.0
// with a parametrised, partially unrolled CORDIC core.
module cordic_param_sincos
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 21,
    parameter int ITERS  = 16,
    parameter int UNROLL = 4
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic        n,
    output logic [31:0] result,
    output logic        done
);

    localparam logic [4:0] ITER_LAST = 5'(ITERS - UNROLL);
    localparam logic [4:0] UNROLL_W  = 5'(UNROLL);

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [WIDTH-1:0] z_q, z_d;
    logic        [4:0]       iter_q, iter_d;
    logic                    mode_q, mode_d;
    logic                    neg_q, neg_d;
    logic                    bad_q, bad_d;
    logic        [31:0]      result_q, result_d;

    logic signed [WIDTH-1:0] atan_rom [32];
    logic signed [WIDTH-1:0] x_c [UNROLL+1];
    logic signed [WIDTH-1:0] y_c [UNROLL+1];
    logic signed [WIDTH-1:0] z_c [UNROLL+1];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rom
            assign atan_rom[gi] = WIDTH'(atan_fixed(gi, WIDTH));
        end
    endgenerate

    assign x_c[0] = x_q;
    assign y_c[0] = y_q;
    assign z_c[0] = z_q;

    generate
        for (gi = 0; gi < UNROLL; gi++) begin : g_stage
            logic [4:0] idx;
            assign idx = iter_q + 5'(gi);
            cordic_stage #(.WIDTH(WIDTH)) u_stage (
                .x_i     (x_c[gi]),
                .y_i     (y_c[gi]),
                .z_i     (z_c[gi]),
                .shift_i (idx),
                .angle_i (atan_rom[idx]),
                .x_o     (x_c[gi+1]),
                .y_o     (y_c[gi+1]),
                .z_o     (z_c[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        iter_d   = iter_q;
        mode_d   = mode_q;
        neg_d    = neg_q;
        bad_d    = bad_q;
        result_d = result_q;
        if (clk_en) begin
            // A start in any state restarts; the abandoned operation never reaches DONE
            if (start) begin
                state_d = ST_RUN;
                x_d     = WIDTH'(k_fixed(WIDTH));
                y_d     = '0;
                z_d     = WIDTH'(float_to_fixed(dataa, WIDTH));
                iter_d  = '0;
                mode_d  = n;
                neg_d   = dataa[31];
                bad_d   = float_is_bad(dataa);
            end else begin
                case (state_q)
                    ST_RUN: begin
                        x_d    = x_c[UNROLL];
                        y_d    = y_c[UNROLL];
                        z_d    = z_c[UNROLL];
                        iter_d = iter_q + UNROLL_W;
                        if (iter_q == ITER_LAST) state_d = ST_CONV;
                    end
                    ST_CONV: begin
                        result_d = bad_q ? NAN_BITS :
                                   fixed_to_float(mode_q ? 32'(y_q) : 32'(x_q), WIDTH,
                                                  neg_q & mode_q);
                        state_d  = ST_DONE;
                    end
                    ST_DONE: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            iter_q   <= '0;
            mode_q   <= 1'b0;
            neg_q    <= 1'b0;
            bad_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            iter_q   <= iter_d;
            mode_q   <= mode_d;
            neg_q    <= neg_d;
            bad_q    <= bad_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_cordic_param_sincos.sv
// Directed bench for cordic_param_sincos: latency, accuracy, sign, abort,
// clock-enable stall, reset and unroll/width parameter variants.
module tb_cordic_param_sincos;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        n;
    logic [31:0] result, result_u1, result_u2, result_u8, result_w24;
    logic        done, done_u1, done_u2, done_u8, done_w24;

    int vectors     = 0;
    int miscompares = 0;

    localparam real TOL16 = 1.0 / 65536.0;
    localparam real TOL15 = 1.0 / 32768.0;
    localparam real TOL14 = 1.0 / 16384.0;
    localparam real TOL19 = 1.0 / 524288.0;
    localparam real COS_HALF    = 0.8775825619;
    localparam real SIN_HALF    = 0.4794255386;
    localparam real SIN_QUARTER = 0.2474039593;

    always #5 clock = ~clock;

    cordic_param_sincos u_dut (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start),
        .dataa(dataa), .n(n), .result(result), .done(done));
    cordic_param_sincos #(.UNROLL(1)) u_u1 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start),
        .dataa(dataa), .n(n), .result(result_u1), .done(done_u1));
    cordic_param_sincos #(.UNROLL(2)) u_u2 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start),
        .dataa(dataa), .n(n), .result(result_u2), .done(done_u2));
    cordic_param_sincos #(.UNROLL(8)) u_u8 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start),
        .dataa(dataa), .n(n), .result(result_u8), .done(done_u8));
    cordic_param_sincos #(.WIDTH(24)) u_w24 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .start(start),
        .dataa(dataa), .n(n), .result(result_w24), .done(done_w24));

    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        r = 1.0 + real'(int'(b[22:0])) / 8388608.0;
        e = int'(b[30:23]);
        for (int k = e; k < 127; k++) r = r / 2.0;
        for (int k = 127; k < e; k++) r = r * 2.0;
        return b[31] ? -r : r;
    endfunction

    function automatic real absr(input real a);
        return (a < 0.0) ? -a : a;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // start is high for the current cycle (cycle 0); returns at the sample point of cycle 1
    task automatic issue(input logic [31:0] a, input logic m);
        dataa = a;
        n     = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic watch(input int first_c, input int last_c, output int fd, output int nd);
        fd = -1;
        nd = 0;
        for (int c = first_c; c <= last_c; c++) begin
            if (done) begin
                if (fd < 0) fd = c;
                nd++;
            end
            if (c != last_c) tick();
        end
    endtask

    task automatic test_reset();
        aclr   = 1'b1;
        clk_en = 1'b0;
        start  = 1'b0;
        dataa  = '0;
        n      = 1'b0;
        repeat (3) tick();
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h expected %h", result, 32'h0);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        $display("reset: result=%h done=%b", result, done);
        aclr   = 1'b0;
        clk_en = 1'b1;
        tick();
    endtask

    task automatic test_cos_zero();
        int fd, nd;
        real r;
        issue(32'h0000_0000, 1'b0);
        watch(1, 8, fd, nd);
        r = f2r(result);
        $display("cos(0): result=%h done_cycle=%0d pulses=%0d", result, fd, nd);
        vectors++;
        if (fd !== 6) begin
            miscompares++;
            $display("FAIL cos0_latency: got cycle %0d expected 6", fd);
        end
        vectors++;
        if (nd !== 1) begin
            miscompares++;
            $display("FAIL cos0_pulses: got %0d expected 1", nd);
        end
        vectors++;
        if (!(result == 32'h3F80_0000 || result[31:8] == 24'h3F7FFF)) begin
            miscompares++;
            $display("FAIL cos0_bits: got %h expected 3f7fffxx or 3f800000", result);
        end
        vectors++;
        if (absr(r - 1.0) >= TOL16) begin
            miscompares++;
            $display("FAIL cos0_value: got %f expected 1.0", r);
        end
    endtask

    task automatic test_half();
        int fd, nd;
        real r;
        issue(32'h3F00_0000, 1'b0);
        watch(1, 8, fd, nd);
        r = f2r(result);
        $display("cos(0.5): result=%h done_cycle=%0d", result, fd);
        vectors++;
        if (fd !== 6) begin
            miscompares++;
            $display("FAIL cos_half_latency: got cycle %0d expected 6", fd);
        end
        vectors++;
        if (absr(r - COS_HALF) >= TOL16) begin
            miscompares++;
            $display("FAIL cos_half_value: got %f expected %f", r, COS_HALF);
        end
        vectors++;
        if (result[31] !== 1'b0) begin
            miscompares++;
            $display("FAIL cos_half_sign: got %b expected 0", result[31]);
        end
        issue(32'h3F00_0000, 1'b1);
        watch(1, 8, fd, nd);
        r = f2r(result);
        $display("sin(0.5): result=%h done_cycle=%0d", result, fd);
        vectors++;
        if (fd !== 6) begin
            miscompares++;
            $display("FAIL sin_half_latency: got cycle %0d expected 6", fd);
        end
        vectors++;
        if (absr(r - SIN_HALF) >= TOL15) begin
            miscompares++;
            $display("FAIL sin_half_value: got %f expected %f", r, SIN_HALF);
        end
        vectors++;
        if (result[31] !== 1'b0) begin
            miscompares++;
            $display("FAIL sin_half_sign: got %b expected 0", result[31]);
        end
    endtask

    task automatic test_neg_half();
        int fd, nd;
        real r;
        issue(32'hBF00_0000, 1'b1);
        watch(1, 8, fd, nd);
        r = f2r(result);
        $display("sin(-0.5): result=%h done_cycle=%0d", result, fd);
        vectors++;
        if (result[31] !== 1'b1) begin
            miscompares++;
            $display("FAIL sin_neg_sign: got %b expected 1", result[31]);
        end
        vectors++;
        if (absr(r + SIN_HALF) >= TOL15) begin
            miscompares++;
            $display("FAIL sin_neg_value: got %f expected %f", r, -SIN_HALF);
        end
        issue(32'hBF00_0000, 1'b0);
        watch(1, 8, fd, nd);
        r = f2r(result);
        $display("cos(-0.5): result=%h done_cycle=%0d", result, fd);
        vectors++;
        if (result[31] !== 1'b0) begin
            miscompares++;
            $display("FAIL cos_neg_sign: got %b expected 0", result[31]);
        end
        vectors++;
        if (absr(r - COS_HALF) >= TOL16) begin
            miscompares++;
            $display("FAIL cos_neg_value: got %f expected %f", r, COS_HALF);
        end
    endtask

    task automatic test_abort();
        int fd1, nd1, fd, nd;
        real r;
        issue(32'h3F00_0000, 1'b0);
        watch(1, 3, fd1, nd1);
        issue(32'h3E80_0000, 1'b1);
        watch(4, 12, fd, nd);
        r = f2r(result);
        $display("abort then sin(0.25): result=%h done_cycle=%0d pulses=%0d", result, fd, nd);
        vectors++;
        if (nd1 !== 0) begin
            miscompares++;
            $display("FAIL abort_early_done: got %0d pulses expected 0", nd1);
        end
        vectors++;
        if (fd !== 9 || nd !== 1) begin
            miscompares++;
            $display("FAIL abort_latency: got cycle %0d (%0d pulses) expected cycle 9 (1 pulse)", fd, nd);
        end
        vectors++;
        if (absr(r - SIN_QUARTER) >= TOL14) begin
            miscompares++;
            $display("FAIL abort_value: got %f expected %f", r, SIN_QUARTER);
        end
    endtask

    task automatic test_clk_en();
        int fd, nd;
        fd = -1;
        nd = 0;
        issue(32'h3F80_0000, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            clk_en = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            if (done) begin
                if (fd < 0) fd = c;
                nd++;
            end
            tick();
        end
        clk_en = 1'b1;
        $display("stalled 1.0: result=%h done_cycle=%0d pulses=%0d", result, fd, nd);
        vectors++;
        if (fd !== 9) begin
            miscompares++;
            $display("FAIL stall_latency: got cycle %0d expected 9", fd);
        end
        vectors++;
        if (nd !== 1) begin
            miscompares++;
            $display("FAIL stall_pulses: got %0d expected 1", nd);
        end
        vectors++;
        if (result !== 32'h7FC0_0000) begin
            miscompares++;
            $display("FAIL range_nan: got %h expected 7fc00000", result);
        end
        repeat (3) tick();
        vectors++;
        if (result !== 32'h7FC0_0000) begin
            miscompares++;
            $display("FAIL result_hold: got %h expected 7fc00000", result);
        end
    endtask

    task automatic test_aclr();
        int nd;
        nd = 0;
        issue(32'h3F00_0000, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            aclr  = (c == 2);
            start = (c == 2);
            dataa = 32'h0;
            if (done) nd++;
            tick();
        end
        aclr  = 1'b0;
        start = 1'b0;
        $display("aclr mid-run: result=%h pulses=%0d", result, nd);
        vectors++;
        if (nd !== 0) begin
            miscompares++;
            $display("FAIL aclr_done: got %0d pulses expected 0", nd);
        end
        vectors++;
        if (result !== 32'h0) begin
            miscompares++;
            $display("FAIL aclr_result: got %h expected 00000000", result);
        end
    endtask

    task automatic test_sweep();
        int fd_u1, fd_u2, fd_u8, fd_w24;
        fd_u1 = -1; fd_u2 = -1; fd_u8 = -1; fd_w24 = -1;
        issue(32'h0000_0000, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (done_u1  && fd_u1  < 0) fd_u1  = c;
            if (done_u2  && fd_u2  < 0) fd_u2  = c;
            if (done_u8  && fd_u8  < 0) fd_u8  = c;
            if (done_w24 && fd_w24 < 0) fd_w24 = c;
            if (c != 20) tick();
        end
        $display("sweep cos(0): u1=%0d u2=%0d u8=%0d w24=%0d w24_result=%h u8_result=%h",
                 fd_u1, fd_u2, fd_u8, fd_w24, result_w24, result_u8);
        vectors++;
        if (fd_u1 !== 18) begin
            miscompares++;
            $display("FAIL unroll1_latency: got cycle %0d expected 18", fd_u1);
        end
        vectors++;
        if (fd_u2 !== 10) begin
            miscompares++;
            $display("FAIL unroll2_latency: got cycle %0d expected 10", fd_u2);
        end
        vectors++;
        if (fd_u8 !== 4) begin
            miscompares++;
            $display("FAIL unroll8_latency: got cycle %0d expected 4", fd_u8);
        end
        vectors++;
        if (fd_w24 !== 6) begin
            miscompares++;
            $display("FAIL width24_latency: got cycle %0d expected 6", fd_w24);
        end
        vectors++;
        if (absr(f2r(result_w24) - 1.0) >= TOL19) begin
            miscompares++;
            $display("FAIL width24_value: got %f expected 1.0", f2r(result_w24));
        end
        vectors++;
        if (absr(f2r(result_u8) - 1.0) >= TOL16) begin
            miscompares++;
            $display("FAIL unroll8_value: got %f expected 1.0", f2r(result_u8));
        end
    endtask

    initial begin
        test_reset();
        test_cos_zero();
        test_half();
        test_neg_half();
        test_abort();
        test_clk_en();
        test_aclr();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
